// File: rtl/gray_code_counter_pkg.sv
// Shared definitions for the Gray-code counter: full-scale constant helper
// and a reference binary-to-Gray conversion used for constant folding.
package gray_code_counter_pkg;

  // Widest count supported by the helpers below.
  localparam int unsigned MAX_W = 64;

  // All-ones value for a counter of the given width (2^w - 1).
  function automatic logic [MAX_W-1:0] cnt_max(input int unsigned w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Reflected binary Gray code: each bit is the XOR of itself and the bit above.
  function automatic logic [MAX_W-1:0] bin_to_gray(input logic [MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_code_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface gray_code_counter_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_cnt;
  logic [WIDTH-1:0] gray_cnt;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, load, load_val,
    input  bin_cnt, gray_cnt, tc, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output bin_cnt, gray_cnt, tc, wrap
  );

endinterface

// File: rtl/gray_code_counter_gray_encode.sv
// Purely combinational binary-to-Gray encoder, one XOR per bit below the MSB.
module gray_encode #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // MSB passes straight through.
  assign gray[WIDTH-1] = bin[WIDTH-1];

  // Every lower bit records whether it differs from its upper neighbour.
  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
    assign gray[i] = bin[i+1] ^ bin[i];
  end

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with synchronous load. The Gray image is encoded
// from the next binary value and registered on the same edge, so both
// outputs always describe the same count and gray_cnt is glitch-free.
module gray_code_counter
  import gray_code_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  gray_code_counter_if.slave cnt_if
);

  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin_to_gray(MAX_W'(RESET_VAL)));

  logic [WIDTH-1:0] bin_cnt_p1;
  logic [WIDTH-1:0] gray_cnt_p1;
  logic             wrap_p1;

  logic [WIDTH-1:0] bin_nxt_p0;
  logic [WIDTH-1:0] gray_nxt_p0;
  logic             at_max_p0;
  logic             at_zero_p0;
  logic             tc_p0;

  // ---- stage p0: next-value selection, terminal count, Gray encoding ----

  assign at_max_p0  = (bin_cnt_p1 == CNT_MAX);
  assign at_zero_p0 = (bin_cnt_p1 == '0);

  // A step wraps when counting up from all-ones or down from zero; load masks it.
  assign tc_p0 = cnt_if.en & ~cnt_if.load &
                 ((cnt_if.up & at_max_p0) | (~cnt_if.up & at_zero_p0));

  // Load beats count beats hold; carry/borrow drop off the top naturally.
  always_comb begin
    bin_nxt_p0 = bin_cnt_p1;
    if (cnt_if.load) begin
      bin_nxt_p0 = cnt_if.load_val;
    end else if (cnt_if.en) begin
      if (cnt_if.up) begin
        bin_nxt_p0 = bin_cnt_p1 + WIDTH'(1);
      end else begin
        bin_nxt_p0 = bin_cnt_p1 - WIDTH'(1);
      end
    end
  end

  gray_encode #(
    .WIDTH (WIDTH)
  ) u_gray_encode (
    .bin  (bin_nxt_p0),
    .gray (gray_nxt_p0)
  );

  // ---- stage p1: output registers ----

  // Binary, Gray and wrap all update together; reset overrides load and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt_p1  <= RESET_BIN;
      gray_cnt_p1 <= RESET_GRAY;
      wrap_p1     <= 1'b0;
    end else begin
      bin_cnt_p1  <= bin_nxt_p0;
      gray_cnt_p1 <= gray_nxt_p0;
      wrap_p1     <= tc_p0;
    end
  end

  assign cnt_if.bin_cnt  = bin_cnt_p1;
  assign cnt_if.gray_cnt = gray_cnt_p1;
  assign cnt_if.wrap     = wrap_p1;
  assign cnt_if.tc       = tc_p0;

endmodule

// File: tb/tb_gray_code_counter.sv
// Randomized and directed bench for gray_code_counter against an integer model.
module tb_gray_code_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic clk;
  logic rst;

  gray_code_counter_if #(.WIDTH(W)) ifc ();

  gray_code_counter #(
    .WIDTH     (W),
    .RESET_VAL (0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cnt_if (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_pass;

  // Reference model state.
  int m_cnt;
  int m_wrap;
  int m_valid;
  int gtab [MOD];

  localparam logic [3:0] PLAN_GRAY [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Gray table built by reflection: mirror the list and set the new top bit.
  task automatic build_gray_table();
    int size;
    gtab[0] = 0;
    gtab[1] = 1;
    size = 2;
    for (int b = 1; b < W; b++) begin
      for (int i = 0; i < size; i++) begin
        gtab[2*size-1-i] = gtab[i] + (1 << b);
      end
      size = size * 2;
    end
  endtask

  // One clock cycle: drive inputs, check tc, clock, update model, check outputs.
  task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                     input logic [W-1:0] lv);
    int exp_tc;
    int nxt;
    int prev_gray;
    rst          = r;
    ifc.en       = e;
    ifc.up       = u;
    ifc.load     = l;
    ifc.load_val = lv;
    #1;
    exp_tc = 0;
    if (m_valid != 0) begin
      if (e && !l) begin
        nxt    = u ? m_cnt + 1 : m_cnt - 1;
        exp_tc = (nxt < 0 || nxt >= MOD) ? 1 : 0;
      end
      chk("tc", int'(ifc.tc), exp_tc);
    end
    prev_gray = int'(ifc.gray_cnt);
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt   = 0;
      m_wrap  = 0;
      m_valid = 1;
    end else if (l) begin
      m_cnt  = int'(lv);
      m_wrap = 0;
    end else if (e) begin
      nxt    = u ? m_cnt + 1 : m_cnt - 1;
      m_wrap = (nxt < 0 || nxt >= MOD) ? 1 : 0;
      m_cnt  = (nxt + MOD) % MOD;
    end else begin
      m_wrap = 0;
    end
    if (m_valid != 0) begin
      chk("bin_cnt", int'(ifc.bin_cnt), m_cnt);
      chk("gray_cnt", int'(ifc.gray_cnt), gtab[m_cnt]);
      chk("wrap", int'(ifc.wrap), m_wrap);
      if (!r && !l && e && exp_tc >= 0) begin
        chk("gray_one_bit", $countones(prev_gray ^ int'(ifc.gray_cnt)), 1);
      end
    end
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    m_cnt   = 0;
    m_wrap  = 0;
    m_valid = 0;
    build_gray_table();

    // Reset for two cycles, then idle.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    end
    chk("reset_bin", int'(ifc.bin_cnt), 0);
    chk("reset_gray", int'(ifc.gray_cnt), 0);

    // Full upward lap through the wrap.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      chk("plan_up_gray", int'(ifc.gray_cnt), int'(PLAN_GRAY[(i + 1) % 16]));
      chk("plan_up_wrap", int'(ifc.wrap), (i == 15) ? 1 : 0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Downward wrap from zero.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("down_wrap_bin", int'(ifc.bin_cnt), 15);
    chk("down_wrap_gray", int'(ifc.gray_cnt), 8);
    chk("down_wrap_pulse", int'(ifc.wrap), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("down_wrap_clear", int'(ifc.wrap), 0);

    // Load wins over count.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010);
    chk("load_bin", int'(ifc.bin_cnt), 10);
    chk("load_gray", int'(ifc.gray_cnt), 15);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    chk("after_load_bin", int'(ifc.bin_cnt), 11);
    chk("after_load_gray", int'(ifc.gray_cnt), 14);

    // Reset wins over load and count.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b1100);
    chk("rst_prio_bin", int'(ifc.bin_cnt), 0);
    chk("rst_prio_gray", int'(ifc.gray_cnt), 0);

    // Direction toggling with no bubble.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    chk("toggle_gray_a", int'(ifc.gray_cnt), 5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("toggle_gray_b", int'(ifc.gray_cnt), 7);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    chk("toggle_bin_c", int'(ifc.bin_cnt), 6);

    // Back-to-back wraps alternating direction at the boundary.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("b2b_wrap", int'(ifc.wrap), 1);

    // Random traffic, biased toward the boundaries.
    for (int i = 0; i < 600; i++) begin
      logic r, e, u, l;
      logic [W-1:0] lv;
      r  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       lv = '0;
        1:       lv = '1;
        default: lv = W'($urandom);
      endcase
      cyc(r, e, u, l, lv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
